// File: rtl/axil_request_master.sv
// axil_request_master
//
// Single-outstanding AXI-lite master. It turns a command/response handshake
// from an internal controller into one AXI-lite read or write transaction at
// a time. It returns the slave's response code unmodified, so SLVERR and
// DECERR reach the controller exactly like OKAY.
//
// Optional feature macro: AXILREQ_TIMEOUT_EN
//   When defined, a LGTIMEOUT-bit watchdog counts the cycles spent waiting on
//   the bus and sets the sticky o_timeout flag when it saturates. The
//   transaction is not aborted. When undefined, o_timeout is constant 0.
//
// Ports
//   S_AXI_ACLK, S_AXI_ARESETN  clock; asynchronous active-low reset
//   i_cmd_*/o_cmd_ready        command in (we, addr, data, strb)
//   o_rsp_*                    one-cycle response pulse; we/data/resp hold
//                              until the next response
//   o_timeout                  sticky watchdog flag
//   M_AXI_AW*/W*/B*            AXI-lite write channels
//   M_AXI_AR*/R*               AXI-lite read channels
module axil_request_master #(
   parameter  int C_AXI_ADDR_WIDTH = 32,
   parameter  int LGTIMEOUT        = 8,
   localparam int C_AXI_DATA_WIDTH = 32
) (
   input  logic                          S_AXI_ACLK,
   input  logic                          S_AXI_ARESETN,
   input  logic                          i_cmd_valid,
   output logic                          o_cmd_ready,
   input  logic                          i_cmd_we,
   input  logic [C_AXI_ADDR_WIDTH-1:0]   i_cmd_addr,
   input  logic [C_AXI_DATA_WIDTH-1:0]   i_cmd_data,
   input  logic [C_AXI_DATA_WIDTH/8-1:0] i_cmd_strb,
   output logic                          o_rsp_valid,
   output logic                          o_rsp_we,
   output logic [C_AXI_DATA_WIDTH-1:0]   o_rsp_data,
   output logic [1:0]                    o_rsp_resp,
   output logic                          o_timeout,
   output logic                          M_AXI_AWVALID,
   input  logic                          M_AXI_AWREADY,
   output logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
   output logic [2:0]                    M_AXI_AWPROT,
   output logic                          M_AXI_WVALID,
   input  logic                          M_AXI_WREADY,
   output logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
   output logic [C_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
   input  logic                          M_AXI_BVALID,
   output logic                          M_AXI_BREADY,
   input  logic [1:0]                    M_AXI_BRESP,
   output logic                          M_AXI_ARVALID,
   input  logic                          M_AXI_ARREADY,
   output logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
   output logic [2:0]                    M_AXI_ARPROT,
   input  logic                          M_AXI_RVALID,
   output logic                          M_AXI_RREADY,
   input  logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
   input  logic [1:0]                    M_AXI_RRESP
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2
   } state_t;

   state_t                          state_q, state_d;
   logic                            awvalid_q, awvalid_d;
   logic                            wvalid_q, wvalid_d;
   logic                            arvalid_q, arvalid_d;
   logic [C_AXI_ADDR_WIDTH-1:0]     addr_q, addr_d;
   logic [C_AXI_DATA_WIDTH-1:0]     wdata_q, wdata_d;
   logic [C_AXI_DATA_WIDTH/8-1:0]   wstrb_q, wstrb_d;
   logic                            rsp_valid_q, rsp_valid_d;
   logic                            rsp_we_q, rsp_we_d;
   logic [C_AXI_DATA_WIDTH-1:0]     rsp_data_q, rsp_data_d;
   logic [1:0]                      rsp_resp_q, rsp_resp_d;

   logic cmd_accept;
   logic b_hs;
   logic r_hs;

   // Ready is held low while reset is asserted so the controller never sees
   // a command window during reset.
   assign o_cmd_ready = (state_q == IDLE) && S_AXI_ARESETN;
   assign cmd_accept  = i_cmd_valid && o_cmd_ready;

   // BREADY is high for the whole WRITE state, but the response is only taken
   // once both address and data have been handed over.
   assign b_hs = (state_q == WRITE) && M_AXI_BVALID && !awvalid_q && !wvalid_q;
   assign r_hs = (state_q == READ) && M_AXI_RVALID;

   always_comb begin
      state_d     = state_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      arvalid_d   = arvalid_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      rsp_valid_d = 1'b0;
      rsp_we_d    = rsp_we_q;
      rsp_data_d  = rsp_data_q;
      rsp_resp_d  = rsp_resp_q;
      case (state_q)
         IDLE: begin
            if (cmd_accept) begin
               addr_d = i_cmd_addr;
               if (i_cmd_we) begin
                  wdata_d   = i_cmd_data;
                  wstrb_d   = i_cmd_strb;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = WRITE;
               end else begin
                  arvalid_d = 1'b1;
                  state_d   = READ;
               end
            end
         end
         WRITE: begin
            // AW and W retire independently, in any order.
            if (M_AXI_AWREADY) awvalid_d = 1'b0;
            if (M_AXI_WREADY)  wvalid_d  = 1'b0;
            if (b_hs) begin
               rsp_valid_d = 1'b1;
               rsp_we_d    = 1'b1;
               rsp_data_d  = '0;
               rsp_resp_d  = M_AXI_BRESP;
               state_d     = IDLE;
            end
         end
         READ: begin
            if (M_AXI_ARREADY) arvalid_d = 1'b0;
            if (r_hs) begin
               rsp_valid_d = 1'b1;
               rsp_we_d    = 1'b0;
               rsp_data_d  = M_AXI_RDATA;
               rsp_resp_d  = M_AXI_RRESP;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         state_q     <= IDLE;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_we_q    <= 1'b0;
         rsp_data_q  <= '0;
         rsp_resp_q  <= 2'b00;
      end else begin
         state_q     <= state_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         arvalid_q   <= arvalid_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_we_q    <= rsp_we_d;
         rsp_data_q  <= rsp_data_d;
         rsp_resp_q  <= rsp_resp_d;
      end
   end

`ifdef AXILREQ_TIMEOUT_EN
   logic [LGTIMEOUT-1:0] tmo_cnt_q, tmo_cnt_d;
   logic                 timeout_q, timeout_d;

   // The counter saturates at all-ones; the flag rises in the same cycle the
   // counter reaches that value and is cleared only by the next command.
   always_comb begin
      tmo_cnt_d = tmo_cnt_q;
      timeout_d = timeout_q;
      if (cmd_accept) begin
         tmo_cnt_d = '0;
         timeout_d = 1'b0;
      end else if ((state_q != IDLE) && !(&tmo_cnt_q)) begin
         tmo_cnt_d = tmo_cnt_q + 1'b1;
         if (&tmo_cnt_d) timeout_d = 1'b1;
      end
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         tmo_cnt_q <= '0;
         timeout_q <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign o_timeout = timeout_q;
`else
   // Watchdog compiled out. The comparison is constant false; it only keeps
   // LGTIMEOUT referenced in this build.
   assign o_timeout = (LGTIMEOUT < 0);
`endif

   assign o_rsp_valid   = rsp_valid_q;
   assign o_rsp_we      = rsp_we_q;
   assign o_rsp_data    = rsp_data_q;
   assign o_rsp_resp    = rsp_resp_q;

   assign M_AXI_AWVALID = awvalid_q;
   assign M_AXI_AWADDR  = addr_q;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_WVALID  = wvalid_q;
   assign M_AXI_WDATA   = wdata_q;
   assign M_AXI_WSTRB   = wstrb_q;
   assign M_AXI_BREADY  = (state_q == WRITE);
   assign M_AXI_ARVALID = arvalid_q;
   assign M_AXI_ARADDR  = addr_q;
   assign M_AXI_ARPROT  = 3'b000;
   assign M_AXI_RREADY  = (state_q == READ);

endmodule

// File: tb/tb_axil_request_master.sv
module tb_axil_request_master;

   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_cmd_valid, i_cmd_we;
   logic [AW-1:0] i_cmd_addr;
   logic [31:0]   i_cmd_data;
   logic [3:0]    i_cmd_strb;
   logic          o_cmd_ready, o_rsp_valid, o_rsp_we, o_timeout;
   logic [31:0]   o_rsp_data;
   logic [1:0]    o_rsp_resp;
   logic          awvalid, awready, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rvalid, rready;
   logic [AW-1:0] awaddr, araddr;
   logic [2:0]    awprot, arprot;
   logic [31:0]   wdata, rdata;
   logic [3:0]    wstrb;
   logic [1:0]    bresp, rresp;

   always #5 clk = ~clk;

   axil_request_master #(.C_AXI_ADDR_WIDTH(AW), .LGTIMEOUT(4)) dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
      .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_we(i_cmd_we),
      .i_cmd_addr(i_cmd_addr), .i_cmd_data(i_cmd_data), .i_cmd_strb(i_cmd_strb),
      .o_rsp_valid(o_rsp_valid), .o_rsp_we(o_rsp_we), .o_rsp_data(o_rsp_data),
      .o_rsp_resp(o_rsp_resp), .o_timeout(o_timeout),
      .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready), .M_AXI_AWADDR(awaddr),
      .M_AXI_AWPROT(awprot),
      .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_WDATA(wdata),
      .M_AXI_WSTRB(wstrb),
      .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_BRESP(bresp),
      .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready), .M_AXI_ARADDR(araddr),
      .M_AXI_ARPROT(arprot),
      .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready), .M_AXI_RDATA(rdata),
      .M_AXI_RRESP(rresp)
   );

`ifdef AXILREQ_TIMEOUT_EN
   localparam logic EXP_TMO = 1'b1;
`else
   localparam logic EXP_TMO = 1'b0;
`endif

   // ---------------- configurable slave model ----------------
   int          aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
   logic        hold_resp = 1'b0;
   logic [1:0]  bresp_k = 2'b00, rresp_k = 2'b00;
   logic [31:0] rdata_k = 32'h0;
   int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
   logic        aw_done, w_done, ar_done, bvalid_r, rvalid_r;
   logic        aw_done_n, w_done_n, ar_done_n;

   assign awready   = (aw_cnt >= aw_wait);
   assign wready    = (w_cnt >= w_wait);
   assign arready   = (ar_cnt >= ar_wait);
   assign bvalid    = bvalid_r;
   assign bresp     = bresp_k;
   assign rvalid    = rvalid_r;
   assign rresp     = rresp_k;
   assign rdata     = rdata_k;
   assign aw_done_n = aw_done | (awvalid & awready);
   assign w_done_n  = w_done | (wvalid & wready);
   assign ar_done_n = ar_done | (arvalid & arready);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
         aw_done <= 1'b0; w_done <= 1'b0; ar_done <= 1'b0;
         bvalid_r <= 1'b0; rvalid_r <= 1'b0;
      end else begin
         if (awvalid && awready) aw_cnt <= 0; else if (awvalid) aw_cnt <= aw_cnt + 1;
         if (wvalid && wready)   w_cnt  <= 0; else if (wvalid)  w_cnt  <= w_cnt + 1;
         if (arvalid && arready) ar_cnt <= 0; else if (arvalid) ar_cnt <= ar_cnt + 1;
         if (bvalid_r && bready) begin
            bvalid_r <= 1'b0; aw_done <= 1'b0; w_done <= 1'b0; b_cnt <= 0;
         end else begin
            aw_done <= aw_done_n; w_done <= w_done_n;
            if (!bvalid_r && aw_done_n && w_done_n && !hold_resp) begin
               if (b_cnt >= b_wait) bvalid_r <= 1'b1; else b_cnt <= b_cnt + 1;
            end
         end
         if (rvalid_r && rready) begin
            rvalid_r <= 1'b0; ar_done <= 1'b0; r_cnt <= 0;
         end else begin
            ar_done <= ar_done_n;
            if (!rvalid_r && ar_done_n && !hold_resp) begin
               if (r_cnt >= r_wait) rvalid_r <= 1'b1; else r_cnt <= r_cnt + 1;
            end
         end
      end
   end

   // ---------------- scoreboard and checking ----------------
   typedef struct {
      logic        we;
      logic [31:0] data;
      logic [1:0]  resp;
   } rsp_t;

   rsp_t sb[$];
   int   n_cmp = 0, n_err = 0, n_rsp = 0, rsp_cyc = 0, cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && o_rsp_valid) begin
         rsp_t e;
         n_rsp++;
         rsp_cyc = cyc;
         if (sb.size() == 0) begin
            check("rsp_unexpected", 64'd1, 64'd0);
         end else begin
            e = sb.pop_front();
            check("rsp_we", o_rsp_we, e.we);
            check("rsp_data", o_rsp_data, e.data);
            check("rsp_resp", o_rsp_resp, e.resp);
         end
      end
   end

   // Drive one command for one cycle; n is the cycle in which it is accepted.
   // Returns at the falling edge of the first cycle after acceptance.
   task automatic send(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] ed, input logic [1:0] er,
                       output int n);
      rsp_t e;
      @(negedge clk);
      i_cmd_valid = 1'b1; i_cmd_we = we; i_cmd_addr = a; i_cmd_data = d; i_cmd_strb = s;
      n = cyc;
      check("cmd_ready", o_cmd_ready, 1'b1);
      e.we = we; e.data = ed; e.resp = er;
      sb.push_back(e);
      @(negedge clk);
      i_cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int r0, input string tag);
      for (int i = 0; i < 60 && n_rsp == r0; i++) begin
         @(negedge clk);
         #1;
      end
      check(tag, (n_rsp != r0), 1'b1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, r0;
      rst_n = 1'b0; i_cmd_valid = 1'b0; i_cmd_we = 1'b0;
      i_cmd_addr = '0; i_cmd_data = '0; i_cmd_strb = '0;
      repeat (3) @(negedge clk);
      check("reset_outputs",
            {o_cmd_ready, awvalid, wvalid, arvalid, bready, rready, o_rsp_valid, o_timeout},
            8'h00);
      check("reset_addr", {awaddr, wdata, o_rsp_data, o_rsp_resp, o_rsp_we}, 67'h0);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_reset", o_cmd_ready, 1'b1);

      // Zero-wait write with minimum turnaround
      r0 = n_rsp;
      send(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 2'b00, n);
      check("wr_valids", {awvalid, wvalid, bready, o_cmd_ready}, 4'b1110);
      check("wr_awaddr", awaddr, 32'h10);
      check("wr_wdata", wdata, 32'hDEADBEEF);
      check("wr_wstrb", wstrb, 4'hF);
      check("wr_prot", {awprot, arprot}, 6'b0);
      wait_rsp(r0, "wr_rsp_seen");
      check("turnaround", rsp_cyc, n + 3);
      check("ready_in_rsp_cycle", o_cmd_ready, 1'b1);
      @(negedge clk);
      check("rsp_pulse_one_cycle", o_rsp_valid, 1'b0);
      check("rsp_hold", {o_rsp_we, o_rsp_data, o_rsp_resp}, {1'b1, 32'h0, 2'b00});

      // Error-only slave: write then read
      aw_wait = 1; w_wait = 1; bresp_k = 2'b11; rresp_k = 2'b11; rdata_k = 32'h0;
      r0 = n_rsp;
      send(1'b1, 32'h20, 32'h11, 4'h3, 32'h0, 2'b11, n);
      wait_rsp(r0, "err_wr_rsp_seen");
      r0 = n_rsp;
      send(1'b0, 32'h24, 32'h0, 4'h0, 32'h0, 2'b11, n);
      check("err_rd_araddr", araddr, 32'h24);
      wait_rsp(r0, "err_rd_rsp_seen");
      repeat (3) @(negedge clk);
      check("err_rsp_count", n_rsp, r0 + 1);

      // W handshake three cycles ahead of AW
      aw_wait = 3; w_wait = 0; bresp_k = 2'b00; rresp_k = 2'b00;
      r0 = n_rsp;
      send(1'b1, 32'h40, 32'hA5A5_0001, 4'h1, 32'h0, 2'b00, n);
      check("wfirst_both_high", {awvalid, wvalid}, 2'b11);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("wfirst_w_dropped_aw_held", {awvalid, wvalid}, 2'b10);
         check("wfirst_awaddr_stable", awaddr, 32'h40);
      end
      @(negedge clk);
      check("wfirst_aw_done", awvalid, 1'b0);
      wait_rsp(r0, "wfirst_rsp_seen");
      repeat (3) @(negedge clk);
      check("wfirst_single_rsp", n_rsp, r0 + 1);

      // Read with a stalled AR channel and a late R
      aw_wait = 0; ar_wait = 5; r_wait = 2; rdata_k = 32'h12345678;
      r0 = n_rsp;
      send(1'b0, 32'h80, 32'h0, 4'h0, 32'h12345678, 2'b00, n);
      for (int k = 0; k < 5; k++) begin
         if (k != 0) @(negedge clk);
         check("rd_stall_arvalid_rready", {arvalid, rready}, 2'b11);
         check("rd_stall_araddr", araddr, 32'h80);
      end
      wait_rsp(r0, "rd_rsp_seen");
      ar_wait = 0; r_wait = 0;

      // Reset while AWVALID is pending
      aw_wait = 100;
      r0 = n_rsp;
      send(1'b1, 32'h90, 32'h5555_AAAA, 4'hF, 32'h0, 2'b00, n);
      @(negedge clk);
      check("pre_reset_awvalid", awvalid, 1'b1);
      rst_n = 1'b0;
      #1;
      check("reset_kills_valids", {awvalid, wvalid, arvalid, bready, rready, o_rsp_valid}, 6'b0);
      void'(sb.pop_back());
      aw_wait = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_midreset", o_cmd_ready, 1'b1);
      repeat (5) @(negedge clk);
      check("no_rsp_after_reset", n_rsp, r0);

      // Unresponsive slave: watchdog, then late completion
      hold_resp = 1'b1;
      r0 = n_rsp;
      send(1'b1, 32'hA0, 32'h0BAD_F00D, 4'hF, 32'h0, 2'b10, n);
      bresp_k = 2'b10;
      repeat (12) @(negedge clk);
      check("tmo_not_yet", o_timeout, 1'b0);
      repeat (3) @(negedge clk);
      check("tmo_at_limit", o_timeout, EXP_TMO);
      check("tmo_still_waiting", {o_cmd_ready, bready}, 2'b01);
      hold_resp = 1'b0;
      wait_rsp(r0, "late_b_rsp_seen");
      check("tmo_sticky_after_rsp", o_timeout, EXP_TMO);
      bresp_k = 2'b00; rdata_k = 32'hCAFE_0001;
      r0 = n_rsp;
      send(1'b0, 32'hB0, 32'h0, 4'h0, 32'hCAFE_0001, 2'b00, n);
      check("tmo_cleared_on_accept", o_timeout, 1'b0);
      wait_rsp(r0, "post_tmo_rsp_seen");

      repeat (3) @(negedge clk);
      check("scoreboard_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
